// File: rtl/gdp_pkg.sv
// Shared definitions for the GEMMV tile datapath: lane packing and deskew depths.
package gdp_pkg;

    localparam int unsigned DEFAULT_CNT_W = 16;

    // Bit offset of lane k inside a packed row.
    function automatic int unsigned lane_offset(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

    // Lane k needs n-1-k extra stages so that all lanes meet lane n-1 at the output register.
    function automatic int unsigned lane_depth(input int unsigned n, input int unsigned k);
        return n - 1 - k;
    endfunction

endpackage

// File: rtl/deskew_lane_delay.sv
// Enable-gated delay line of DEPTH registers; DEPTH=0 is a plain wire.
module deskew_lane_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, en};
        assign q = d;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else if (en) begin
                stage_q[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/data_deskew.sv
// Realigns diagonally skewed PE-array output lanes into whole rows with a single row-valid.
module data_deskew
    import gdp_pkg::*;
#(
    parameter int unsigned data_width         = 20,
    parameter int unsigned a_tile_column_size = 4,
    parameter int unsigned CNT_W              = DEFAULT_CNT_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [data_width*a_tile_column_size-1:0] din,
    input  logic [a_tile_column_size-1:0]        din_valid,
    output logic [data_width*a_tile_column_size-1:0] dout,
    output logic                                 dout_valid,
    output logic                                 align_err,
    output logic [CNT_W-1:0]                     row_cnt
);

    localparam int unsigned N  = a_tile_column_size;
    localparam int unsigned LW = data_width + 1;

    logic [N-1:0]            lane_v;
    logic [data_width*N-1:0] lane_d;

    // Each lane carries its valid bit as the MSB of the delayed word.
    for (genvar k = 0; k < int'(N); k++) begin : g_lane
        logic [LW-1:0] lane_q;

        deskew_lane_delay #(
            .WIDTH(LW),
            .DEPTH(lane_depth(N, k))
        ) u_delay (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .d    ({din_valid[k], din[lane_offset(k, data_width) +: data_width]}),
            .q    (lane_q)
        );

        assign lane_v[k] = lane_q[LW-1];
        assign lane_d[lane_offset(k, data_width) +: data_width] = lane_q[data_width-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            align_err  <= 1'b0;
            row_cnt    <= '0;
        end else if (en) begin
            dout <= lane_d;
            if (&lane_v) begin
                dout_valid <= 1'b1;
                row_cnt    <= row_cnt + CNT_W'(1);
            end else begin
                dout_valid <= 1'b0;
                if (|lane_v) begin
                    align_err <= 1'b1;
                end
            end
        end else begin
            // A stalled edge must not repeat the previous row-valid.
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_deskew.sv
// Self-checking bench for data_deskew: directed tables, corner sequences and random traffic.
module tb_data_deskew;

    localparam int unsigned DW = 20;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned W  = DW * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  din;
    logic [N-1:0]  din_valid;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          align_err;
    logic [CW-1:0] row_cnt;

    always #5 clk = ~clk;

    data_deskew #(
        .data_width        (DW),
        .a_tile_column_size(N),
        .CNT_W             (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .align_err (align_err),
        .row_cnt   (row_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of sampled rows per enabled edge.
    typedef struct {
        logic [N-1:0] v;
        logic [W-1:0] d;
    } sample_t;

    sample_t       hist[$];
    logic [W-1:0]  m_dout;
    logic          m_dv;
    logic          m_err;
    logic [CW-1:0] m_cnt;

    logic [W-1:0]  pulse_rows[$];
    logic [DW-1:0] rowdat[0:31][0:N-1];

    typedef struct {
        logic          e;
        logic [N-1:0]  v;
        logic [W-1:0]  d;
        logic          exp_dv;
        logic [CW-1:0] exp_cnt;
        logic          chk_d;
        logic [W-1:0]  exp_d;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return W'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [W-1:0] put(input logic [W-1:0] base, input int k,
                                         input logic [DW-1:0] val);
        logic [W-1:0] r;
        r = base;
        r[k*DW +: DW] = val;
        return r;
    endfunction

    function automatic logic [W-1:0] pack_row(input int r);
        logic [W-1:0] p;
        p = '0;
        for (int k = 0; k < int'(N); k++) p[k*DW +: DW] = rowdat[r][k];
        return p;
    endfunction

    // Lane k of the output row was sampled N-1-k enabled edges ago.
    function automatic void model_edge(input logic r, input logic e, input logic [W-1:0] d,
                                       input logic [N-1:0] v);
        sample_t      s;
        logic [N-1:0] vv;
        logic [W-1:0] dd;
        int           age;
        int           idx;
        if (!r) begin
            hist.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_err  = 1'b0;
            m_cnt  = '0;
        end else if (!e) begin
            m_dv = 1'b0;
        end else begin
            s.v = v;
            s.d = d;
            hist.push_back(s);
            if (hist.size() > int'(N)) void'(hist.pop_front());
            vv = '0;
            dd = '0;
            for (int k = 0; k < int'(N); k++) begin
                age = int'(N) - 1 - k;
                if (hist.size() > age) begin
                    idx = hist.size() - 1 - age;
                    vv[k] = hist[idx].v[k];
                    dd[k*DW +: DW] = hist[idx].d[k*DW +: DW];
                end
            end
            m_dout = dd;
            if (vv == '1) begin
                m_dv  = 1'b1;
                m_cnt = m_cnt + 1'b1;
            end else begin
                m_dv = 1'b0;
                if (vv != '0) m_err = 1'b1;
            end
        end
    endfunction

    task automatic cyc(input logic r, input logic e, input logic [W-1:0] d, input logic [N-1:0] v);
        rst_n     = r;
        en        = e;
        din       = d;
        din_valid = v;
        @(posedge clk);
        model_edge(r, e, d, v);
        #1;
        check("dout", dout, m_dout);
        check("dout_valid", W'(dout_valid), W'(m_dv));
        check("align_err", W'(align_err), W'(m_err));
        check("row_cnt", W'(row_cnt), W'(m_cnt));
        if (dout_valid === 1'b1) pulse_rows.push_back(dout);
    endtask

    task automatic stream(input int nrows, input int stall_pct);
        int           t;
        int           r;
        logic         e;
        logic [W-1:0] d;
        logic [N-1:0] v;
        pulse_rows.delete();
        t = 0;
        while (t < nrows + int'(N) - 1) begin
            e = ($urandom_range(99) >= stall_pct);
            d = rnd_w();
            v = '0;
            if (e) begin
                for (int k = 0; k < int'(N); k++) begin
                    r = t - k;
                    if (r >= 0 && r < nrows) begin
                        d[k*DW +: DW] = rowdat[r][k];
                        v[k] = 1'b1;
                    end
                end
                t++;
            end else begin
                v = N'($urandom());
            end
            cyc(1'b1, e, d, v);
        end
        cyc(1'b1, 1'b1, rnd_w(), '0);
        check("stream_count", W'(pulse_rows.size()), W'(nrows));
        for (int j = 0; j < pulse_rows.size(); j++) check("stream_row", pulse_rows[j], pack_row(j));
    endtask

    task automatic fill_random_rows();
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < int'(N); k++) rowdat[r][k] = DW'($urandom());
    endtask

    initial begin
        logic [W-1:0] row2;
        row2 = {20'h01003, 20'h01002, 20'h01001, 20'h01000};

        // Reset holds everything at zero regardless of inputs.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, rnd_w(), '1);
            check("rst_dout", dout, '0);
            check("rst_dv", W'(dout_valid), '0);
            check("rst_err", W'(align_err), '0);
            check("rst_cnt", W'(row_cnt), '0);
        end
        cyc(1'b1, 1'b1, '0, '0);
        check("post_rst_dv", W'(dout_valid), '0);
        check("post_rst_cnt", W'(row_cnt), '0);
        check("post_rst_err", W'(align_err), '0);

        // Single skewed row from a table.
        for (int k = 0; k < int'(N); k++) begin
            tbl[k].e       = 1'b1;
            tbl[k].v       = N'(1) << k;
            tbl[k].d       = put('0, k, DW'(32'h01000 + k));
            tbl[k].exp_dv  = (k == int'(N) - 1);
            tbl[k].exp_cnt = (k == int'(N) - 1) ? CW'(1) : CW'(0);
            tbl[k].chk_d   = (k == int'(N) - 1);
            tbl[k].exp_d   = row2;
        end
        tbl[4] = '{e: 1'b1, v: '0, d: '0, exp_dv: 1'b0, exp_cnt: CW'(1), chk_d: 1'b0, exp_d: '0};
        cyc(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, tbl[i].e, tbl[i].d, tbl[i].v);
            check("t2_dv", W'(dout_valid), W'(tbl[i].exp_dv));
            check("t2_cnt", W'(row_cnt), W'(tbl[i].exp_cnt));
            if (tbl[i].chk_d) check("t2_dout", dout, tbl[i].exp_d);
        end

        // Eight back-to-back rows, row 0 lane 0 negative.
        cyc(1'b0, 1'b1, '0, '0);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < int'(N); k++) rowdat[r][k] = DW'(r * 16 + k);
        rowdat[0][0] = 20'hFFFFF;
        stream(8, 0);
        check("t3_cnt", W'(row_cnt), W'(8));
        check("t3_err", W'(align_err), '0);

        // Alternating stall: row appears on the 7th clock.
        cyc(1'b0, 1'b1, '0, '0);
        pulse_rows.delete();
        for (int c = 0; c < 7; c++) begin
            if (c % 2 == 0) cyc(1'b1, 1'b1, put('0, c / 2, DW'(32'h01000 + c / 2)), N'(1) << (c / 2));
            else cyc(1'b1, 1'b0, rnd_w(), N'($urandom()));
            check("t4_dv", W'(dout_valid), W'(c == 6));
        end
        check("t4_dout", dout, row2);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b0, rnd_w(), '1);
            check("t4_hold_dout", dout, row2);
            check("t4_hold_dv", W'(dout_valid), '0);
        end
        check("t4_pulses", W'(pulse_rows.size()), W'(1));

        // Lane 2 one enabled edge late.
        cyc(1'b0, 1'b1, '0, '0);
        pulse_rows.delete();
        cyc(1'b1, 1'b1, put('0, 0, 20'h00AAA), 4'b0001);
        cyc(1'b1, 1'b1, put('0, 1, 20'h00BBB), 4'b0010);
        cyc(1'b1, 1'b1, '0, '0);
        cyc(1'b1, 1'b1, put(put('0, 2, 20'h00CCC), 3, 20'h00DDD), 4'b1100);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, '0, '0);
            check("t5_err", W'(align_err), W'(1));
        end
        check("t5_pulses", W'(pulse_rows.size()), '0);
        check("t5_cnt", W'(row_cnt), '0);
        fill_random_rows();
        stream(1, 0);
        check("t5_recover_cnt", W'(row_cnt), W'(1));
        check("t5_err_sticky", W'(align_err), W'(1));

        // Reset mid-row discards partial rows.
        cyc(1'b0, 1'b1, '0, '0);
        pulse_rows.delete();
        cyc(1'b1, 1'b1, put('0, 0, 20'h12345), 4'b0001);
        cyc(1'b1, 1'b1, put('0, 1, 20'h23456), 4'b0010);
        cyc(1'b0, 1'b1, rnd_w(), '1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, '0, '0);
        check("t6_pulses", W'(pulse_rows.size()), '0);
        check("t6_cnt", W'(row_cnt), '0);

        // 2^CW rows wrap the counter to zero.
        fill_random_rows();
        stream(16, 0);
        check("t6_wrap_cnt", W'(row_cnt), '0);

        // Random stalled streams and unconstrained traffic.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, '0, '0);
            fill_random_rows();
            stream(10, 30);
        end
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(39) != 0), ($urandom_range(3) != 0), rnd_w(), N'($urandom()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
